// File: rtl/plru_array_pkg.sv
// Shared PLRU types and the tree-update function used by the array and its scoreboard.
// Types are sized for the largest supported tree; callers zero-extend and truncate.
package plru_array_pkg;

  localparam int unsigned MaxWayW = 6;
  localparam int unsigned MaxWays = 1 << MaxWayW;

  typedef logic [MaxWays-2:0] plru_bits_t;
  typedef logic [MaxWayW-1:0] way_t;

  // Point every node on the path of `way` away from it; heap order, root at bit 0.
  function automatic plru_bits_t plru_update(plru_bits_t bits, way_t way, int unsigned way_w);
    plru_bits_t nb  = bits;
    way_t       w   = way << (MaxWayW - way_w);
    way_t       idx = '0;
    for (int unsigned i = 0; i < MaxWayW; i++) begin
      if (i < way_w) begin
        nb[idx] = ~w[MaxWayW-1];
        idx     = (idx << 1) + way_t'(1) + way_t'(w[MaxWayW-1]);
        w       = w << 1;
      end
    end
    return nb;
  endfunction

endpackage

// File: rtl/plru_victim.sv
// Combinational victim select: lowest invalid way wins, else walk the PLRU tree.
module plru_victim #(
  parameter  int unsigned NUM_WAYS = 4,
  localparam int unsigned WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-2:0] bits,
  input  logic [NUM_WAYS-1:0] valid_mask,
  output logic [WAY_W-1:0]    way,
  output logic                invalid
);

  typedef logic [WAY_W-1:0]      way_idx_t;
  typedef logic [WAY_W:0]        node_t;
  typedef logic [2*NUM_WAYS-1:0] pad_t;

  way_idx_t inv_way;
  way_idx_t tree_way;
  pad_t     padded;
  node_t    idx;

  always_comb begin
    invalid = 1'b0;
    inv_way = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!valid_mask[i]) begin
        invalid = 1'b1;
        inv_way = way_idx_t'(i);
      end
    end
  end

  // Padding keeps the node index one bit wider than a way index for every size.
  always_comb begin
    padded = pad_t'(bits);
    idx    = '0;
    for (int l = 0; l < WAY_W; l++) begin
      idx = (idx << 1) + node_t'(1) + node_t'(padded[idx]);
    end
    tree_way = way_idx_t'(idx - node_t'(NUM_WAYS - 1));
  end

  assign way = invalid ? inv_way : tree_way;

endmodule

// File: rtl/plru_array.sv
// Per-set tree pseudo-LRU tracker: update port marks a way MRU, read port yields the victim.
module plru_array
  import plru_array_pkg::*;
#(
  parameter  int unsigned NUM_WAYS = 4,
  parameter  int unsigned NUM_SETS = 8,
  localparam int unsigned WAY_W    = $clog2(NUM_WAYS),
  localparam int unsigned SET_W    = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                upd_valid,
  input  logic [SET_W-1:0]    upd_set,
  input  logic [WAY_W-1:0]    upd_way,
  input  logic                clear,
  input  logic [SET_W-1:0]    rd_set,
  input  logic [NUM_WAYS-1:0] rd_valid_mask,
  output logic [WAY_W-1:0]    replace_way,
  output logic                replace_invalid
);

  typedef logic [NUM_WAYS-2:0] set_bits_t;

  localparam logic [SET_W:0] SetLimit = NUM_SETS[SET_W:0];

  set_bits_t        state_q [NUM_SETS];
  set_bits_t        upd_next;
  set_bits_t        rd_bits;
  logic             upd_hit;
  logic             rd_hit;
  logic [SET_W-1:0] upd_idx;
  logic [SET_W-1:0] rd_idx;
  logic [WAY_W-1:0] victim_way;
  logic             victim_invalid;

  assign upd_hit = {1'b0, upd_set} < SetLimit;
  assign rd_hit  = {1'b0, rd_set} < SetLimit;
  assign upd_idx = upd_hit ? upd_set : '0;
  assign rd_idx  = rd_hit ? rd_set : '0;

  assign upd_next = set_bits_t'(plru_update(plru_bits_t'(state_q[upd_idx]), way_t'(upd_way),
                                            WAY_W));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_SETS; s++) state_q[s] <= '0;
    end else if (clear) begin
      for (int s = 0; s < NUM_SETS; s++) state_q[s] <= '0;
    end else if (upd_valid && upd_hit) begin
      state_q[upd_idx] <= upd_next;
    end
  end

  assign rd_bits = state_q[rd_idx];

  plru_victim #(
    .NUM_WAYS(NUM_WAYS)
  ) u_victim (
    .bits      (rd_bits),
    .valid_mask(rd_valid_mask),
    .way       (victim_way),
    .invalid   (victim_invalid)
  );

  // No bypass: a same-set update this cycle is not reflected until the next one.
  assign replace_way     = rd_hit ? victim_way : '0;
  assign replace_invalid = rd_hit & victim_invalid;

endmodule

// File: tb/tb_plru_array.sv
// Directed checks on a 4-way/8-set array plus a scoreboarded random run on 8-way/16-set.
module tb_plru_array;
  import plru_array_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4_n, upd4_valid, clear4, inv4;
  logic [2:0] upd4_set, rd4_set;
  logic [1:0] upd4_way, way4;
  logic [3:0] mask4;

  logic       rst8_n, upd8_valid, clear8, inv8;
  logic [3:0] upd8_set, rd8_set;
  logic [2:0] upd8_way, way8;
  logic [7:0] mask8;

  int total = 0;
  int bad   = 0;

  plru_array #(.NUM_WAYS(4), .NUM_SETS(8)) dut4 (
    .clk(clk), .reset_n(rst4_n), .upd_valid(upd4_valid), .upd_set(upd4_set),
    .upd_way(upd4_way), .clear(clear4), .rd_set(rd4_set), .rd_valid_mask(mask4),
    .replace_way(way4), .replace_invalid(inv4)
  );

  plru_array #(.NUM_WAYS(8), .NUM_SETS(16)) dut8 (
    .clk(clk), .reset_n(rst8_n), .upd_valid(upd8_valid), .upd_set(upd8_set),
    .upd_way(upd8_way), .clear(clear8), .rd_set(rd8_set), .rd_valid_mask(mask8),
    .replace_way(way8), .replace_invalid(inv8)
  );

  function automatic logic [2:0] model_victim8(plru_bits_t b);
    logic [6:0] node = 7'd1;
    for (int l = 0; l < 3; l++) node = {node[5:0], 1'b0} + 7'(b[6'(node - 7'd1)]);
    return 3'(node - 7'd8);
  endfunction

  task automatic test_reset();
    for (int s = 0; s < 8; s++) begin
      rd4_set = 3'(s);
      #1;
      total++;
      if (way4 !== 2'd0 || inv4 !== 1'b0) begin
        bad++;
        $display("FAIL reset4 set=%0d: got way=%0d inv=%0b want way=0 inv=0", s, way4, inv4);
      end
    end
    rd8_set = 4'd9;
    #1;
    total++;
    if (way8 !== 3'd0 || inv8 !== 1'b0) begin
      bad++;
      $display("FAIL reset8: got way=%0d inv=%0b want way=0 inv=0", way8, inv8);
    end
    @(negedge clk);
    rst4_n = 1'b1;
    rst8_n = 1'b1;
  endtask

  task automatic test_update();
    @(negedge clk);
    upd4_valid = 1'b1; upd4_set = 3'd3; upd4_way = 2'd0; mask4 = 4'b1111;
    @(negedge clk);
    upd4_valid = 1'b0; rd4_set = 3'd3;
    #1;
    total++;
    if (way4 !== 2'd2 || inv4 !== 1'b0) begin
      bad++;
      $display("FAIL update_way0: got way=%0d inv=%0b want way=2 inv=0", way4, inv4);
    end
    upd4_valid = 1'b1; upd4_way = 2'd2;
    @(negedge clk);
    upd4_valid = 1'b0;
    #1;
    total++;
    if (way4 !== 2'd1 || inv4 !== 1'b0) begin
      bad++;
      $display("FAIL update_way2: got way=%0d inv=%0b want way=1 inv=0", way4, inv4);
    end
    for (int s = 0; s < 8; s++) begin
      if (s != 3) begin
        rd4_set = 3'(s);
        #1;
        total++;
        if (way4 !== 2'd0) begin
          bad++;
          $display("FAIL update_other set=%0d: got way=%0d want way=0", s, way4);
        end
      end
    end
  endtask

  // Set 3 holds a tree pointing at way 1; set 0 is still all zero.
  task automatic test_invalid_priority();
    logic [2:0] sets [7]  = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd3, 3'd3};
    logic [3:0] masks [7] = '{4'b1011, 4'b1111, 4'b0000, 4'b0111, 4'b1110, 4'b1111, 4'b1101};
    logic [1:0] ways [7]  = '{2'd2, 2'd0, 2'd0, 2'd3, 2'd0, 2'd1, 2'd1};
    logic       invs [7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 7; k++) begin
      rd4_set = sets[k];
      mask4   = masks[k];
      #1;
      total++;
      if (way4 !== ways[k] || inv4 !== invs[k]) begin
        bad++;
        $display("FAIL invalid_pri vec=%0d: got way=%0d inv=%0b want way=%0d inv=%0b",
                 k, way4, inv4, ways[k], invs[k]);
      end
    end
    mask4 = 4'b1111;
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    rd4_set = 3'd3; upd4_valid = 1'b1; upd4_set = 3'd3; upd4_way = 2'd1;
    #1;
    total++;
    if (way4 !== 2'd1) begin
      bad++;
      $display("FAIL same_cycle_old: got way=%0d want way=1", way4);
    end
    @(negedge clk);
    upd4_valid = 1'b0;
    #1;
    total++;
    if (way4 !== 2'd3) begin
      bad++;
      $display("FAIL same_cycle_new: got way=%0d want way=3", way4);
    end
  endtask

  task automatic test_clear();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      upd4_valid = 1'b1;
      upd4_set   = 3'($urandom_range(0, 7));
      upd4_way   = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    clear4 = 1'b1; upd4_valid = 1'b1; upd4_set = 3'd0; upd4_way = 2'd0;
    @(negedge clk);
    clear4 = 1'b0; upd4_valid = 1'b0;
    for (int s = 0; s < 8; s++) begin
      rd4_set = 3'(s);
      #1;
      total++;
      if (way4 !== 2'd0 || inv4 !== 1'b0) begin
        bad++;
        $display("FAIL clear set=%0d: got way=%0d inv=%0b want way=0 inv=0", s, way4, inv4);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [4] = '{2'd3, 2'd1, 2'd2, 2'd0};
    logic [1:0] exp [5] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd3};
    rd4_set = 3'd5;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      upd4_valid = (k < 4);
      upd4_set   = 3'd5;
      upd4_way   = (k < 4) ? seq[k] : 2'd0;
      #1;
      total++;
      if (way4 !== exp[k]) begin
        bad++;
        $display("FAIL back_to_back step=%0d: got way=%0d want way=%0d", k, way4, exp[k]);
      end
    end
    upd4_valid = 1'b0;
  endtask

  task automatic test_random8();
    plru_bits_t model [16];
    logic [2:0] ew;
    logic       ei;
    for (int s = 0; s < 16; s++) model[s] = '0;
    @(negedge clk);
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) begin
        upd8_valid = 1'b1; upd8_set = 4'd2; upd8_way = 3'd5; mask8 = 8'hFF;
        #2;
        rst8_n = 1'b0;
        for (int s = 0; s < 16; s++) model[s] = '0;
        for (int s = 0; s < 16; s++) begin
          rd8_set = 4'(s);
          #1;
          total++;
          if (way8 !== 3'd0 || inv8 !== 1'b0) begin
            bad++;
            $display("FAIL async_reset set=%0d: got way=%0d inv=%0b want way=0 inv=0",
                     s, way8, inv8);
          end
        end
        @(negedge clk);
        rst8_n = 1'b1; upd8_valid = 1'b0;
        @(negedge clk);
      end
      upd8_valid = ($urandom_range(0, 3) != 0);
      upd8_set   = 4'($urandom_range(0, 15));
      upd8_way   = 3'($urandom_range(0, 7));
      rd8_set    = 4'($urandom_range(0, 15));
      mask8      = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'hFF;
      #1;
      ew = model_victim8(model[rd8_set]);
      ei = 1'b0;
      for (int k = 7; k >= 0; k--) begin
        if (!mask8[k]) begin
          ew = 3'(k);
          ei = 1'b1;
        end
      end
      total++;
      if (way8 !== ew || inv8 !== ei) begin
        bad++;
        $display("FAIL random8 iter=%0d set=%0d: got way=%0d inv=%0b want way=%0d inv=%0b",
                 i, rd8_set, way8, inv8, ew, ei);
      end
      if (upd8_valid) model[upd8_set] = plru_update(model[upd8_set], way_t'(upd8_way), 3);
      @(negedge clk);
    end
    upd8_valid = 1'b0;
  endtask

  initial begin
    rst4_n = 1'b0; upd4_valid = 1'b0; upd4_set = '0; upd4_way = '0; clear4 = 1'b0;
    rd4_set = '0; mask4 = 4'b1111;
    rst8_n = 1'b0; upd8_valid = 1'b0; upd8_set = '0; upd8_way = '0; clear8 = 1'b0;
    rd8_set = '0; mask8 = 8'hFF;
    #2;
    test_reset();
    test_update();
    test_invalid_priority();
    test_same_cycle();
    test_clear();
    test_back_to_back();
    test_random8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
